// File: rtl/dcache_controller_if.sv
// CPU load/store port and block memory port of the data cache.
// The slave side is the controller; the master side is the CPU plus memory.
interface dcache_controller_if;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    modport slave (
        input  read, write, address, writedata,
        input  mem_readdata, mem_busywait,
        output readdata, busywait,
        output mem_read, mem_write, mem_address, mem_writedata
    );

    modport master (
        output read, write, address, writedata,
        output mem_readdata, mem_busywait,
        input  readdata, busywait,
        input  mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache: 8 lines x 4 bytes.
// Hits complete with no stall; misses run write-back, fetch and update.
module dcache_controller (
    input logic           clock,
    input logic           reset,
    dcache_controller_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        UPDATE
    } state_t;

    state_t      state;
    logic [31:0] data  [8];
    logic [2:0]  tags  [8];
    logic [7:0]  valid;
    logic [7:0]  dirty;
    logic [31:0] refill;

    logic [2:0]  tag_in;
    logic [2:0]  idx;
    logic [1:0]  off;
    logic [4:0]  bit_lo;
    logic        req;
    logic        wr_req;
    logic        hit;
    logic [31:0] line;

    assign tag_in = bus.address[7:5];
    assign idx    = bus.address[4:2];
    assign off    = bus.address[1:0];
    assign bit_lo = {off, 3'b000};
    assign req    = bus.read ^ bus.write;
    assign wr_req = bus.write & ~bus.read;
    assign hit    = valid[idx] && (tags[idx] == tag_in);
    assign line   = data[idx];

    assign bus.readdata = line[bit_lo +: 8];
    assign bus.busywait = req && !(state == IDLE && hit);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state             <= IDLE;
            valid             <= '0;
            dirty             <= '0;
            refill            <= '0;
            bus.mem_read      <= 1'b0;
            bus.mem_write     <= 1'b0;
            bus.mem_address   <= '0;
            bus.mem_writedata <= '0;
            for (int i = 0; i < 8; i++) begin
                data[i] <= '0;
                tags[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (req && !hit) begin
                        // Dirty victim must reach memory before the refill
                        if (valid[idx] && dirty[idx]) begin
                            state             <= WRITEBACK;
                            bus.mem_write     <= 1'b1;
                            bus.mem_address   <= {tags[idx], idx};
                            bus.mem_writedata <= data[idx];
                        end else begin
                            state           <= FETCH;
                            bus.mem_read    <= 1'b1;
                            bus.mem_address <= bus.address[7:2];
                        end
                    end else if (wr_req && hit) begin
                        data[idx][bit_lo +: 8] <= bus.writedata;
                        dirty[idx]             <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (!bus.mem_busywait) begin
                        state           <= FETCH;
                        bus.mem_write   <= 1'b0;
                        bus.mem_read    <= 1'b1;
                        bus.mem_address <= bus.address[7:2];
                    end
                end
                FETCH: begin
                    if (!bus.mem_busywait) begin
                        state        <= UPDATE;
                        bus.mem_read <= 1'b0;
                        refill       <= bus.mem_readdata;
                    end
                end
                UPDATE: begin
                    state      <= IDLE;
                    data[idx]  <= refill;
                    tags[idx]  <= tag_in;
                    valid[idx] <= 1'b1;
                    dirty[idx] <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed cases plus random traffic checked
// against an array-level cache/memory model with a 5-cycle busy memory.
module tb_dcache_controller;
    localparam int M = 5;
    localparam int W = 5;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dcache_controller_if bus ();

    dcache_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Backing memory: busy for M cycles per transfer, then completes
    logic [31:0] seed [64];
    logic [31:0] phys [64];
    logic        load_mem = 1'b1;
    int          cnt = 0;
    int          wb_count = 0;
    int          rd_count = 0;
    logic [5:0]  last_wb_addr = '0;
    logic [31:0] last_wb_data = '0;
    logic        mreq;

    assign mreq             = bus.mem_read | bus.mem_write;
    assign bus.mem_busywait = mreq && (cnt < M);
    assign bus.mem_readdata = phys[bus.mem_address];

    always @(posedge clock) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) phys[i] <= seed[i];
        end
        if (!mreq) begin
            cnt <= 0;
        end else if (cnt >= M) begin
            cnt <= 0;
            if (bus.mem_write) begin
                phys[bus.mem_address] <= bus.mem_writedata;
                wb_count     <= wb_count + 1;
                last_wb_addr <= bus.mem_address;
                last_wb_data <= bus.mem_writedata;
            end else begin
                rd_count <= rd_count + 1;
            end
        end else begin
            cnt <= cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) chk("mem exclusive", 32'(bus.mem_read & bus.mem_write), 0);
    end

    // Reference model: expected memory image and cache contents
    logic [31:0] rmem   [64];
    logic [31:0] cdata  [8];
    logic [2:0]  ctag   [8];
    logic        cvalid [8];
    logic        cdirty [8];
    int          exp_wb = 0;
    int          exp_rd = 0;
    logic [5:0]  exp_wb_addr;
    logic [31:0] exp_wb_data;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            cdata[i]  = '0;
            ctag[i]   = '0;
            cvalid[i] = 1'b0;
            cdirty[i] = 1'b0;
        end
    endtask

    task automatic access(input logic rd, input logic wr,
                          input logic [7:0] a, input logic [7:0] wd,
                          input string tag);
        int         exp_stall;
        int         stall;
        int         sh;
        bit         did_wb;
        logic [7:0] exp_byte;
        logic [2:0] i;
        i         = a[4:2];
        sh        = 8 * int'(a[1:0]);
        exp_stall = 0;
        did_wb    = 0;
        exp_byte  = '0;
        if (rd ^ wr) begin
            if (!(cvalid[i] && ctag[i] == a[7:5])) begin
                if (cvalid[i] && cdirty[i]) begin
                    exp_stall   = W + M + 4;
                    exp_wb_addr = {ctag[i], i};
                    exp_wb_data = cdata[i];
                    rmem[exp_wb_addr] = cdata[i];
                    exp_wb++;
                    did_wb = 1;
                end else begin
                    exp_stall = M + 3;
                end
                exp_rd++;
                cdata[i]  = rmem[{a[7:5], i}];
                ctag[i]   = a[7:5];
                cvalid[i] = 1'b1;
                cdirty[i] = 1'b0;
            end
            if (wr) begin
                cdata[i]  = (cdata[i] & ~(32'hFF << sh)) | (32'(wd) << sh);
                cdirty[i] = 1'b1;
            end
            exp_byte = 8'(cdata[i] >> sh);
        end

        bus.read      = rd;
        bus.write     = wr;
        bus.address   = a;
        bus.writedata = wd;
        #1;
        if (rd && wr) chk({tag, " no mem op"}, 32'(mreq), 0);
        stall = 0;
        while (bus.busywait && stall < 200) begin
            @(negedge clock);
            #1;
            stall++;
        end
        chk({tag, " stall"}, stall, exp_stall);
        if (rd && !wr) chk({tag, " rdata"}, 32'(bus.readdata), 32'(exp_byte));
        @(posedge clock);
        @(negedge clock);
        bus.read  = 1'b0;
        bus.write = 1'b0;
        chk({tag, " wb count"}, wb_count, exp_wb);
        chk({tag, " fetch count"}, rd_count, exp_rd);
        if (did_wb) begin
            chk({tag, " wb addr"}, 32'(last_wb_addr), 32'(exp_wb_addr));
            chk({tag, " wb data"}, last_wb_data, exp_wb_data);
        end
    endtask

    initial begin
        int   diffs;
        int   sel;
        logic [7:0] ra;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = '0;
        bus.writedata = '0;
        for (int i = 0; i < 64; i++) seed[i] = $urandom;
        seed[0] = 32'h44332211;
        for (int i = 0; i < 64; i++) rmem[i] = seed[i];
        model_reset();

        repeat (2) @(negedge clock);
        load_mem = 1'b0;
        chk("rst readdata", 32'(bus.readdata), 0);
        chk("rst busywait", 32'(bus.busywait), 0);
        chk("rst mem_read", 32'(bus.mem_read), 0);
        chk("rst mem_write", 32'(bus.mem_write), 0);
        chk("rst mem_address", 32'(bus.mem_address), 0);
        chk("rst mem_writedata", bus.mem_writedata, 0);
        reset = 1'b1;
        @(negedge clock);

        access(1, 0, 8'h00, 8'h00, "cold rd 00");
        access(1, 0, 8'h03, 8'h00, "hit rd 03");
        access(0, 1, 8'h05, 8'hAB, "cold wr 05");
        access(1, 0, 8'h05, 8'h00, "hit rd 05");
        access(1, 0, 8'h25, 8'h00, "dirty evict 25");
        access(1, 0, 8'h05, 8'h00, "restore rd 05");
        access(1, 0, 8'h08, 8'h00, "fill rd 08");
        access(1, 0, 8'h28, 8'h00, "clean evict 28");
        access(1, 0, 8'hFF, 8'h00, "edge rd FF");

        bus.read    = 1'b1;
        bus.address = 8'h14;
        repeat (2) @(negedge clock);
        chk("mid fetch mem_read", 32'(bus.mem_read), 1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rst edge mem_read", 32'(bus.mem_read), 0);
        chk("rst edge mem_write", 32'(bus.mem_write), 0);
        bus.read = 1'b0;
        #1;
        chk("rst edge busywait", 32'(bus.busywait), 0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(negedge clock);

        access(1, 0, 8'h00, 8'h00, "re-miss rd 00");
        access(1, 1, 8'h10, 8'h5A, "both 10");
        access(1, 0, 8'h10, 8'h00, "after both rd 10");

        for (int n = 0; n < 60; n++) begin
            ra  = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3))};
            sel = $urandom_range(0, 9);
            if (sel == 0)     access(1, 1, ra, 8'($urandom), "rnd both");
            else if (sel < 5) access(1, 0, ra, 8'h00, "rnd rd");
            else              access(0, 1, ra, 8'($urandom), "rnd wr");
        end

        diffs = 0;
        for (int i = 0; i < 64; i++) if (phys[i] !== rmem[i]) diffs++;
        chk("memory image", diffs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache controller between the CPU load/store port and the 256x8-bit block-organised data memory, whose interface is a 6-bit block address, 32-bit data and busywait. It holds 8 blocks of 4 bytes with tag, valid and dirty state. It serves byte hits with zero stall. It sequences the write-back and refill transfers on a miss, and stalls the CPU through busywait until the miss completes.

## Interface
- No parameters. Geometry is fixed:
  - 8 lines x 4 bytes.
  - CPU address split: tag = address[7:5], index = address[4:2], offset = address[1:0].
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-low; one clock, reset is synchronous and active-low (reset==0 at a posedge resets).
- read  in  1  CPU byte load request, held until busywait low at a posedge.
- write  in  1  CPU byte store request, same hold rule.
- address  in  8  CPU byte address.
- writedata  in  8  CPU store data.
- readdata  out  8  load data, combinational byte of indexed line selected by offset.
- busywait  out  1  CPU stall, combinational.
- mem_read  out  1  memory block read request.
- mem_write  out  1  memory block write request.
- mem_address  out  6  memory block address {tag,index}.
- mem_writedata  out  32  block to write back; byte k = offset k.
- mem_readdata  in  32  refill block; byte k = offset k.
- mem_busywait  in  1  memory busy.

## Operation
- Storage: 8 x 32-bit data, 8 x 3-bit tag, 8 valid bits, 8 dirty bits.
- hit = valid[index] && tag[index]==address[7:5].
- Request = read XOR write. read && write together is ignored: busywait=0, no state or array change.
- FSM states: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE, no request: hold state.
- IDLE, read hit: readdata = line[index] byte[offset]. busywait=0. No state change.
- IDLE, write hit: at posedge, byte[offset] of line[index] <= writedata and dirty[index] <= 1. busywait=0.
- IDLE, miss with valid && dirty victim: busywait=1, go to WRITEBACK.
- IDLE, miss otherwise: busywait=1, go to FETCH.
- WRITEBACK:
  - Drives mem_write=1, mem_address={tag[index],index}, mem_writedata=line[index].
  - Stays while mem_busywait=1.
  - At the first posedge with mem_busywait=0 after at least one cycle in state, goes to FETCH.
- FETCH:
  - Drives mem_read=1, mem_address=address[7:2].
  - Same exit rule as WRITEBACK, going to UPDATE.
  - mem_readdata is captured into a refill register on that exit edge.
- UPDATE:
  - One cycle. mem_read=mem_write=0.
  - At posedge: line[index] <= refill, tag <= address[7:5], valid <= 1, dirty <= 0. Go to IDLE.
  - The request is now a hit and completes per IDLE rules, so a store merges its byte and sets dirty then.
- busywait = (read XOR write) && !(state==IDLE && hit).
- mem_read and mem_write are registered and decoded from state. Never both high.
- mem_address and mem_writedata are stable for the whole WRITEBACK/FETCH residency.
- CPU must hold address, writedata and request stable while busywait=1. A change mid-miss is unsupported.

## Timing
- Reset (reset==0 at posedge):
  - state=IDLE.
  - All valid, dirty, tag and data cleared to 0.
  - mem_read=0, mem_write=0, mem_address=0, mem_writedata=0.
  - busywait=0 while no request. readdata=8'h00.
- Reset mid-miss: the in-flight transfer is abandoned and mem_read/mem_write drop on the reset edge. Dirty data is lost. The CPU reissues.
- Read hit or write hit: 0 stall cycles. Completes on the posedge where it is presented.
- Clean miss: 1 cycle IDLE decision, FETCH for M+1 cycles (M = memory busy cycles), 1 UPDATE cycle, then the hit edge. Stall = M+3 cycles.
- Dirty miss: adds WRITEBACK of W+1 cycles. Stall = W+M+4 cycles.
- Index wrap: addresses 8'h00 and 8'h20 conflict on line 0. 8'hFF maps to tag 7, index 7, offset 3.

## Test plan
- After reset, read 8'h00 -> busywait high; FETCH asserts mem_read with mem_address=6'h00. Memory returns 32'h44332211 -> readdata=8'h11. Stall = M+3. Then read 8'h03 -> 8'h44 with no stall.
- Write 8'hAB to 8'h05 (line 1 cold miss) -> refill, then byte 1 set and dirty[1]=1. Read 8'h05 -> 8'hAB with 0 stall. mem_write never asserted.
- Dirty eviction: after the previous case, read 8'h25 -> WRITEBACK with mem_address=6'h01 and mem_writedata byte1=8'hAB. Then FETCH mem_address=6'h09. Read 8'h05 again -> 8'hAB restored from memory.
- Clean eviction: fill line 2 via read 8'h08, then read 8'h28 -> no mem_write pulse; FETCH only.
- Reset (reset=0) mid-FETCH -> mem_read=0 after that edge, state IDLE, busywait=0 with request removed. Read 8'h00 misses again.
- read=write=1 at 8'h10 -> busywait=0, no mem_read/mem_write, no array change. Memory model with 5-cycle busywait verifies every latency figure above.
